// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory block port between the I-cache (read-only) and D-cache (read/write).
// Non-preemptive round-robin arbitration with one transaction in flight; MEM_* outputs are registered.
//
// state   | meaning
// IDLE    | no transaction in flight; arbitrate pending requests
// GRANT   | strobe asserted to memory; wait for busy to rise and then fall
// RELEASE | one cycle; owner's BUSYWAIT drops so it can take its data
module mem_bus_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t state;
  logic   last;
  logic   seen;
  logic   owner;
  logic   op_write;
  logic   i_req;
  logic   d_req;
  logic   pick;
  logic   pick_write;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  // With both ports pending the one that was not served last wins.
  always_comb begin
    pick = PORT_I;
    if (i_req && d_req) begin
      pick = ~last;
    end else if (d_req) begin
      pick = PORT_D;
    end
  end

  assign pick_write = (pick == PORT_D) & D_WRITE;

  assign I_BUSYWAIT = i_req & ~((state == RELEASE) && (owner == PORT_I));
  assign D_BUSYWAIT = d_req & ~((state == RELEASE) && (owner == PORT_D));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      last          <= PORT_I;
      seen          <= 1'b0;
      owner         <= PORT_I;
      op_write      <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner       <= pick;
            op_write    <= pick_write;
            MEM_ADDRESS <= (pick == PORT_D) ? D_ADDRESS : I_ADDRESS;
            if (pick == PORT_D) begin
              MEM_WRITEDATA <= D_WRITEDATA;
            end
            MEM_WRITE   <= pick_write;
            MEM_READ    <= ~pick_write;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // Completion is only trusted after memory has shown busy at least once.
          if (MEM_BUSYWAIT) begin
            seen <= 1'b1;
          end else if (seen) begin
            if (!op_write) begin
              if (owner == PORT_D) begin
                D_READDATA <= MEM_READDATA;
              end else begin
                I_READDATA <= MEM_READDATA;
              end
            end
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            last      <= owner;
            seen      <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of request scenarios, a behavioural memory with
// programmable busy time, and a scoreboard checked at each RELEASE cycle.
module tb_mem_bus_arbiter;

  logic        CLK;
  logic        RESET;
  logic        I_READ;
  logic [5:0]  I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ;
  logic        D_WRITE;
  logic [5:0]  D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  mem_bus_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] pat(input logic [5:0] a);
    if (a == 6'h05) return 32'hDEADBEEF;
    return {a, 2'b10, ~a, 2'b01, a, 2'b11, ~a, 2'b00};
  endfunction

  // Memory model: busy for mem_lat edges after it sees a strobe, data valid as busy falls.
  int   mem_lat = 2;
  int   mcnt;
  logic mdone;
  logic mop_rd;
  logic [5:0] maddr;

  always @(posedge CLK) begin
    if (RESET) begin
      MEM_BUSYWAIT <= 1'b0;
      MEM_READDATA <= 32'h0;
      mcnt         <= 0;
      mdone        <= 1'b0;
    end else if (MEM_BUSYWAIT) begin
      if (mcnt == 1) begin
        MEM_BUSYWAIT <= 1'b0;
        mdone        <= 1'b1;
        if (mop_rd) MEM_READDATA <= pat(maddr);
      end
      mcnt <= mcnt - 1;
    end else if (mdone) begin
      mdone <= 1'b0;
    end else if (MEM_READ || MEM_WRITE) begin
      MEM_BUSYWAIT <= 1'b1;
      MEM_READDATA <= 32'hBAADF00D;
      mcnt         <= mem_lat;
      maddr        <= MEM_ADDRESS;
      mop_rd       <= MEM_READ;
    end
  end

  typedef struct {
    logic       owner;
    logic       wr;
    logic [5:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];

  // Monitor / scoreboard
  logic        mon_on = 1'b0;
  logic        prev_strobe = 1'b0;
  logic        g_wr;
  logic        rd_seen;
  logic        unstable;
  logic [5:0]  g_addr;
  logic [31:0] g_wdata;
  logic [31:0] exp_i_rd = 32'h0;
  logic [31:0] exp_d_rd = 32'h0;
  logic        m_irel;
  logic        m_drel;
  int          cyc = 0;
  int          cyc_grant = 0;
  txn_t        e;

  always @(negedge CLK) begin
    if (RESET) begin
      prev_strobe = 1'b0;
      exp_i_rd    = 32'h0;
      exp_d_rd    = 32'h0;
    end else if (mon_on) begin
      cyc++;
      m_irel = I_READ && !I_BUSYWAIT;
      m_drel = (D_READ || D_WRITE) && !D_BUSYWAIT;
      if ((MEM_READ || MEM_WRITE) && !prev_strobe) begin
        g_wr      = MEM_WRITE;
        rd_seen   = MEM_READ;
        g_addr    = MEM_ADDRESS;
        g_wdata   = MEM_WRITEDATA;
        unstable  = 1'b0;
        cyc_grant = cyc;
      end else if (MEM_READ || MEM_WRITE) begin
        rd_seen = rd_seen | MEM_READ;
        if (MEM_ADDRESS !== g_addr || MEM_WRITE !== g_wr) unstable = 1'b1;
      end
      prev_strobe = MEM_READ || MEM_WRITE;
      if (m_irel || m_drel) begin
        if (sb.size() == 0) begin
          chk("unexpected_release", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("one_release", {31'd0, m_irel && m_drel}, 32'd0);
          chk("owner", {31'd0, m_drel}, {31'd0, e.owner});
          chk("op_write", {31'd0, g_wr}, {31'd0, e.wr});
          chk("read_strobe_seen", {31'd0, rd_seen}, {31'd0, !e.wr});
          chk("mem_addr", {26'd0, g_addr}, {26'd0, e.addr});
          if (e.wr) chk("mem_wdata", g_wdata, e.wdata);
          chk("strobe_stable", {31'd0, unstable}, 32'd0);
          chk("latency", 32'(cyc - cyc_grant), 32'(mem_lat + 2));
          chk("strobes_off", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
          if (!e.wr) begin
            if (e.owner) exp_d_rd = pat(e.addr);
            else         exp_i_rd = pat(e.addr);
          end
          chk("i_readdata", I_READDATA, exp_i_rd);
          chk("d_readdata", D_READDATA, exp_d_rd);
          chk("other_busy", {31'd0, m_irel ? D_BUSYWAIT : I_BUSYWAIT},
              {31'd0, m_irel ? (D_READ || D_WRITE) : I_READ});
        end
      end else begin
        chk("busy_hold", {29'd0, MEM_READ && MEM_WRITE, I_BUSYWAIT, D_BUSYWAIT},
            {29'd0, 1'b0, I_READ, D_READ || D_WRITE});
      end
    end
  end

  typedef struct {
    int          i_cnt;
    int          d_cnt;
    logic        d_rd;
    logic        d_wr;
    logic [5:0]  i_base;
    logic [5:0]  d_base;
    logic [31:0] wbase;
    int          lat;
    int          n;
    logic [3:0]  order;   // bit k = owner of k-th completed transaction (1 = D)
  } vec_t;

  task automatic drive(input vec_t v);
    I_READ      = (v.i_cnt > 0);
    I_ADDRESS   = v.i_base;
    D_READ      = v.d_rd && (v.d_cnt > 0);
    D_WRITE     = v.d_wr && (v.d_cnt > 0);
    D_ADDRESS   = v.d_base;
    D_WRITEDATA = v.wbase;
    mem_lat     = v.lat;
  endtask

  task automatic push(input vec_t v);
    int   ij = 0;
    int   dj = 0;
    txn_t t;
    for (int k = 0; k < v.n; k++) begin
      if (v.order[k]) begin
        t.owner = 1'b1;
        t.wr    = v.d_wr;
        t.addr  = 6'(v.d_base + 6'(dj));
        t.wdata = v.wbase + 32'(dj);
        dj++;
      end else begin
        t.owner = 1'b0;
        t.wr    = 1'b0;
        t.addr  = 6'(v.i_base + 6'(ij));
        t.wdata = 32'h0;
        ij++;
      end
      sb.push_back(t);
    end
  endtask

  // Requesters: hold until BUSYWAIT=0 is seen, then re-request the next block or drop.
  task automatic serve(input vec_t v);
    int   i_left = v.i_cnt;
    int   d_left = v.d_cnt;
    int   ij = 0;
    int   dj = 0;
    int   cycles = 0;
    logic i_rel;
    logic d_rel;
    while ((i_left > 0 || d_left > 0) && cycles < 300) begin
      @(negedge CLK);
      i_rel = I_READ && !I_BUSYWAIT;
      d_rel = (D_READ || D_WRITE) && !D_BUSYWAIT;
      @(posedge CLK);
      #1;
      if (i_rel) begin
        i_left--;
        ij++;
        if (i_left == 0) I_READ = 1'b0;
        else I_ADDRESS = 6'(v.i_base + 6'(ij));
      end
      if (d_rel) begin
        d_left--;
        dj++;
        if (d_left == 0) begin
          D_READ  = 1'b0;
          D_WRITE = 1'b0;
        end else begin
          D_ADDRESS   = 6'(v.d_base + 6'(dj));
          D_WRITEDATA = v.wbase + 32'(dj);
        end
      end
      cycles++;
    end
    if (cycles >= 300) chk("serve_timeout", 32'(i_left + d_left), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t h1;
  vec_t h5;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    h1 = '{1, 1, 1'b1, 1'b0, 6'h01, 6'h02, 32'h0, 2, 2, 4'b0001};
    h5 = '{0, 1, 1'b1, 1'b0, 6'h00, 6'h0C, 32'h0, 6, 1, 4'b0001};
    vecs[0] = '{1, 0, 1'b0, 1'b0, 6'h05, 6'h00, 32'h0,        5, 1, 4'b0000};
    vecs[1] = '{1, 2, 1'b1, 1'b0, 6'h08, 6'h20, 32'h0,        3, 3, 4'b0101};
    vecs[2] = '{0, 1, 1'b0, 1'b1, 6'h00, 6'h3F, 32'h01234567, 4, 1, 4'b0001};
    vecs[3] = '{0, 1, 1'b1, 1'b1, 6'h00, 6'h10, 32'hA5A50001, 2, 1, 4'b0001};
    vecs[4] = '{2, 2, 1'b1, 1'b0, 6'h30, 6'h18, 32'h0,        1, 4, 4'b1010};
    vecs[5] = '{1, 1, 1'b0, 1'b1, 6'h00, 6'h2A, 32'hCAFE0000, 2, 2, 4'b0010};

    // Reset with both ports requesting
    RESET = 1'b1;
    drive(h1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("rst_i_busy", {31'd0, I_BUSYWAIT}, 32'd1);
    chk("rst_d_busy", {31'd0, D_BUSYWAIT}, 32'd1);
    chk("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_i_rdata", I_READDATA, 32'd0);
    chk("rst_d_rdata", D_READDATA, 32'd0);
    mon_on = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    push(h1);
    serve(h1);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      push(vecs[i]);
      serve(vecs[i]);
    end

    // Reset in the third GRANT cycle of a D read abandons it
    drive(h5);
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!MEM_READ && w < 50);
    chk("t5_grant", {31'd0, MEM_READ}, 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("t5_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("t5_d_rdata", D_READDATA, 32'd0);
    chk("t5_d_busy", {31'd0, D_BUSYWAIT}, 32'd1);
    push(h5);
    serve(h5);

    repeat (3) @(posedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
